wb_copy_engine: RTL and testbench

- Synthesizable Wishbone classic initiator that copies a block of 32-bit words from a source address to a destination address.
- Each word is copied as one read beat followed by one write beat.
- Used by the test infrastructure and SoC to preload or relocate code and data in unified memory, e.g. to exercise FENCE.I and self-modifying-code paths.
- It is the initiator counterpart to the unified-memory Wishbone responder that serves the core's iwb/dwb ports.

---
 rtl/wb_copy_engine_pkg.sv | 21 ++
 rtl/wb_copy_engine_beat_timer.sv | 32 +++
 rtl/wb_copy_engine.sv | 166 ++++++++++++++++
 tb/tb_wb_copy_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_copy_engine_pkg.sv
// Shared constants for the Wishbone block-copy initiator:
// FSM state codes, bus select/stride constants, address helper.
package wb_copy_engine_pkg;

  localparam logic [2:0] WB_CE_IDLE   = 3'd0;
  localparam logic [2:0] WB_CE_RD     = 3'd1;
  localparam logic [2:0] WB_CE_RD_GAP = 3'd2;
  localparam logic [2:0] WB_CE_WR     = 3'd3;
  localparam logic [2:0] WB_CE_WR_GAP = 3'd4;
  localparam logic [2:0] WB_CE_FIN    = 3'd5;

  localparam logic [3:0]  WB_SEL_WORD    = 4'hF;
  localparam logic [31:0] WB_WORD_STRIDE = 32'd4;

  function automatic logic [31:0] wb_word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/wb_copy_engine_beat_timer.sv
// Beat watchdog: reloads while idle or on a response,
// counts down while a beat is outstanding.
// Ports: i_clk, i_rst (async high), i_run (beat active),
//        i_resp (ack or err seen), o_expired (abort now).
module wb_beat_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_resp,
  output logic o_expired
);

  localparam logic [15:0] LOAD = 16'(TIMEOUT);

  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= LOAD;
    end else if (!i_run || i_resp) begin
      r_cnt <= LOAD;
    end else if (r_cnt != 16'd0) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  // Fires in the TIMEOUT-th silent cycle of a beat.
  assign o_expired = i_run && !i_resp && (r_cnt == 16'd1);

endmodule

// File: rtl/wb_copy_engine.sv
// Wishbone classic initiator copying len_words words src->dst,
// one read beat then one write beat per word, ascending order.
// Ports: start/src_addr/dst_addr/len_words request; busy/done/
//        error/err_addr status; wb_* classic initiator bus.
module wb_copy_engine #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      err_addr,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  import wb_copy_engine_pkg::*;

  logic [2:0]       r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_rem;
  logic [31:0]      r_data;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [31:0]      r_err_addr;
  logic [31:0]      r_adr;
  logic [31:0]      r_dat;
  logic             r_we;
  logic             r_cyc;
  logic             r_stb;

  logic w_run;
  logic w_expired;
  logic w_abort;

  assign w_run   = (r_state == WB_CE_RD) || (r_state == WB_CE_WR);
  assign w_abort = wb_err_i || w_expired;

  wb_beat_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_run     (w_run),
    .i_resp    (wb_ack_i || wb_err_i),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= WB_CE_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_rem      <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_addr <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_we       <= 1'b0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        WB_CE_IDLE: begin
          if (start) begin
            r_src   <= wb_word_align(src_addr);
            r_dst   <= wb_word_align(dst_addr);
            r_rem   <= len_words;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            if (len_words == '0) begin
              r_state <= WB_CE_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= WB_CE_RD;
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_we    <= 1'b0;
              r_adr   <= wb_word_align(src_addr);
            end
          end
        end
        WB_CE_RD, WB_CE_WR: begin
          // err has priority over a simultaneous ack.
          if (w_abort) begin
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_error    <= 1'b1;
            r_err_addr <= r_adr;
            r_done     <= 1'b1;
            r_state    <= WB_CE_FIN;
          end else if (wb_ack_i) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            if (r_state == WB_CE_RD) begin
              r_data  <= wb_dat_i;
              r_state <= WB_CE_RD_GAP;
            end else begin
              r_src   <= r_src + WB_WORD_STRIDE;
              r_dst   <= r_dst + WB_WORD_STRIDE;
              r_rem   <= r_rem - LEN_W'(1);
              r_state <= WB_CE_WR_GAP;
            end
          end
        end
        WB_CE_RD_GAP: begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_we    <= 1'b1;
          r_adr   <= r_dst;
          r_dat   <= r_data;
          r_state <= WB_CE_WR;
        end
        WB_CE_WR_GAP: begin
          if (r_rem == '0) begin
            r_done  <= 1'b1;
            r_state <= WB_CE_FIN;
          end else begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_adr   <= r_src;
            r_state <= WB_CE_RD;
          end
        end
        WB_CE_FIN: begin
          r_busy  <= 1'b0;
          r_state <= WB_CE_IDLE;
        end
        default: r_state <= WB_CE_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign err_addr = r_err_addr;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign wb_we_o  = r_we;
  assign wb_sel_o = WB_SEL_WORD;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_stb;

endmodule

// File: tb/tb_wb_copy_engine.sv
// Scoreboard bench for wb_copy_engine: a memory responder,
// a copy reference model and a bus/done monitor.
module tb_wb_copy_engine;

  localparam int TO  = 8;
  localparam int LIM = 500;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  typedef struct {
    logic        err;
    logic [31:0] ea;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len_words;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] err_addr;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  beat_t beat_q[$];
  res_t  res_q[$];
  logic [31:0] mem     [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];

  bit noack    = 1'b0;
  int err_beat = -1;
  int beat_no  = 0;
  bit prev_ack = 1'b0;
  beat_t mb;
  res_t  mr;

  always #5 clk = ~clk;

  wb_copy_engine #(
    .LEN_W   (16),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len_words (len_words),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_addr  (err_addr),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  // Registered 1-cycle responder with error injection by beat index.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      wb_dat_i <= 32'h0;
    end else begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && !noack) begin
        if (beat_no == err_beat) begin
          wb_err_i <= 1'b1;
        end else begin
          wb_ack_i <= 1'b1;
          if (wb_we_o) mem[wb_adr_o] = wb_dat_o;
          else wb_dat_i <= mem_rd(wb_adr_o);
        end
        beat_no++;
      end
    end
  end

  // Monitor: pops expected beats and completions.
  always @(negedge clk) begin
    if (rst) begin
      prev_ack = 1'b0;
    end else begin
      if (wb_cyc_o) cyc_cnt++;
      if (prev_ack) chk("gap_cyc", 32'(wb_cyc_o), 32'h0);
      prev_ack = wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i);
      if (prev_ack) begin
        if (beat_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat: got beat adr %h, required none", wb_adr_o);
        end else begin
          mb = beat_q.pop_front();
          chk("beat_adr", wb_adr_o, mb.adr);
          chk("beat_we", 32'(wb_we_o), 32'(mb.we));
          if (mb.we) chk("beat_dat", wb_dat_o, mb.dat);
          chk("beat_sel", 32'(wb_sel_o), 32'hF);
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_done: got done, required none");
        end else begin
          mr = res_q.pop_front();
          chk("done_error", 32'(error), 32'(mr.err));
          if (mr.err) chk("err_addr", err_addr, mr.ea);
        end
      end
    end
  end

  // Reference: ascending word copy; err_at = failing beat index.
  task automatic plan(input logic [31:0] src, input logic [31:0] dst,
                      input int len, input int err_at);
    logic [31:0] s;
    logic [31:0] d;
    logic [31:0] w;
    int k;
    k = 0;
    s = {src[31:2], 2'b00};
    d = {dst[31:2], 2'b00};
    for (int i = 0; i < len; i++) begin
      w = ref_rd(s);
      beat_q.push_back('{s, 1'b0, 32'h0});
      if (k == err_at) begin
        res_q.push_back('{1'b1, s});
        return;
      end
      k++;
      beat_q.push_back('{d, 1'b1, w});
      if (k == err_at) begin
        res_q.push_back('{1'b1, d});
        return;
      end
      k++;
      ref_mem[d] = w;
      s = s + 32'd4;
      d = d + 32'd4;
    end
    res_q.push_back('{1'b0, 32'h0});
  endtask

  // lat = cycles from the start-sampling edge until done is seen.
  task automatic do_copy(input logic [31:0] src, input logic [31:0] dst,
                         input int len, output int lat);
    int bc;
    @(negedge clk);
    start     = 1'b1;
    src_addr  = src;
    dst_addr  = dst;
    len_words = 16'(len);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    bc    = 0;
    while (!done && lat < LIM) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", lat);
    end
    if (busy) bc++;
    @(negedge clk);
    chk("done_once", 32'(done), 32'h0);
    chk("busy_fall", 32'(busy), 32'h0);
    chk("busy_cycles", 32'(bc), 32'(lat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end, required $finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int c0;
    int n;
    int ln;
    int ea;
    logic [31:0] s;
    logic [31:0] d;

    rst       = 1'b1;
    start     = 1'b0;
    src_addr  = 32'h0;
    dst_addr  = 32'h0;
    len_words = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
    chk("rst_stb", 32'(wb_stb_o), 32'h0);
    chk("rst_we", 32'(wb_we_o), 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) poke(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
    c0 = cyc_cnt;
    plan(32'h1000, 32'h2000, 4, -1);
    do_copy(32'h1000, 32'h2000, 4, lat);
    chk("t1_latency", 32'(lat), 32'd25);
    chk("t1_cyc_cycles", 32'(cyc_cnt - c0), 32'd16);
    for (int i = 0; i < 4; i++)
      chk("t1_dst", mem_rd(32'h2000 + 32'(4 * i)), 32'hA0 + 32'(i));

    c0 = cyc_cnt;
    plan(32'h1000, 32'h2000, 0, -1);
    do_copy(32'h1000, 32'h2000, 0, lat);
    chk("t2_latency", 32'(lat), 32'd1);
    chk("t2_no_cyc", 32'(cyc_cnt - c0), 32'h0);

    poke(32'h1004, 32'h55);
    err_beat = beat_no + 3;
    plan(32'h1000, 32'h2000, 4, 3);
    do_copy(32'h1000, 32'h2000, 4, lat);
    err_beat = -1;
    chk("t3_latency", 32'(lat), 32'd12);
    chk("t3_sticky", 32'(error), 32'h1);
    chk("t3_err_addr", err_addr, 32'h2004);
    chk("t3_no_write", mem_rd(32'h2004), 32'hA1);
    plan(32'h1000, 32'h2000, 1, -1);
    do_copy(32'h1000, 32'h2000, 1, lat);
    chk("t3_cleared", 32'(error), 32'h0);

    noack = 1'b1;
    res_q.push_back('{1'b1, 32'h1000});
    do_copy(32'h1000, 32'h7000, 2, lat);
    noack = 1'b0;
    chk("t4_latency", 32'(lat), 32'(TO + 1));
    chk("t4_err_addr", err_addr, 32'h1000);

    beat_q.push_back('{32'h1000, 1'b0, 32'h0});
    @(negedge clk);
    start     = 1'b1;
    src_addr  = 32'h1000;
    dst_addr  = 32'h3000;
    len_words = 16'd1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(wb_cyc_o && wb_we_o) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("t5_in_write", 32'(wb_cyc_o && wb_we_o), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t5_cyc", 32'(wb_cyc_o), 32'h0);
    chk("t5_stb", 32'(wb_stb_o), 32'h0);
    chk("t5_we", 32'(wb_we_o), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_not_written", mem_rd(32'h3000), 32'h0);
    plan(32'h1000, 32'h3000, 1, -1);
    do_copy(32'h1000, 32'h3000, 1, lat);
    chk("t5_copy", mem_rd(32'h3000), 32'hA0);

    poke(32'hFFFF_FFFC, 32'h1111_1111);
    poke(32'h0000_0000, 32'h2222_2222);
    plan(32'hFFFF_FFFC, 32'h5000, 2, -1);
    do_copy(32'hFFFF_FFFC, 32'h5000, 2, lat);
    chk("t6_wrap0", mem_rd(32'h5000), 32'h1111_1111);
    chk("t6_wrap1", mem_rd(32'h5004), 32'h2222_2222);
    plan(32'h1003, 32'h6002, 1, -1);
    do_copy(32'h1003, 32'h6002, 1, lat);
    chk("t6_unaligned", mem_rd(32'h6000), 32'hA0);

    for (int i = 0; i < 64; i++) poke(32'h8000 + 32'(4 * i), $urandom);
    for (int t = 0; t < 12; t++) begin
      s  = 32'h8000 + 32'(4 * $urandom_range(0, 40)) + 32'($urandom_range(0, 3));
      d  = 32'h8000 + 32'(4 * $urandom_range(0, 40)) + 32'($urandom_range(0, 3));
      ln = int'($urandom_range(0, 6));
      ea = -1;
      if (ln > 0 && $urandom_range(0, 3) == 0)
        ea = int'($urandom_range(0, 2 * ln - 1));
      err_beat = (ea < 0) ? -1 : beat_no + ea;
      plan(s, d, ln, ea);
      do_copy(s, d, ln, lat);
      err_beat = -1;
    end
    for (int i = 0; i < 128; i++)
      chk("rand_mem", mem_rd(32'h8000 + 32'(4 * i)), ref_rd(32'h8000 + 32'(4 * i)));

    repeat (2) @(negedge clk);
    chk("beat_q_empty", 32'(beat_q.size()), 32'h0);
    chk("res_q_empty", 32'(res_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
